// File: rtl/multiple_sequencer.sv
// multiple_sequencer: decode-stage expander for LM/SM instructions.
// Issues one micro-op per selected register with zero latency (Mealy),
// stalling the PC and the IF/ID register until the last micro-op issues.
// Every other instruction passes straight through.
module multiple_sequencer #(
  parameter logic [3:0]  LM_OP    = 4'b0110,
  parameter logic [3:0]  SM_OP    = 4'b0111,
  parameter logic [15:0] NOP_WORD = 16'hF000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] in_IR,
  input  logic        hold,
  input  logic        flush,
  output logic [15:0] out_IR,
  output logic [2:0]  reg_index,
  output logic [2:0]  offset,
  output logic        first_multiple,
  output logic        stall,
  output logic        busy
);

  typedef enum logic {IDLE = 1'b0, SEQ = 1'b1} state_t;

  state_t      state, stateNext;
  logic [15:0] irQ, irNext;
  logic [7:0]  maskQ, maskNext;
  logic [2:0]  cntQ, cntNext;

  logic        isMult;
  logic [7:0]  list;
  logic [7:0]  rest;
  logic [2:0]  cur;

  // Active register list and its lowest selected register.
  always_comb begin
    isMult = (in_IR[15:12] == LM_OP) || (in_IR[15:12] == SM_OP);
    list   = (state == SEQ) ? maskQ : in_IR[7:0];
    cur    = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (list[i]) cur = 3'(i);
    end
    // Clearing the lowest set bit is the same as clearing bit 'cur'.
    rest = list & (list - 8'd1);
  end

  // Next-state and micro-op outputs; flush beats hold, reset beats both.
  always_comb begin
    out_IR         = in_IR;
    reg_index      = 3'd0;
    offset         = 3'd0;
    first_multiple = 1'b0;
    stall          = 1'b0;
    stateNext      = state;
    irNext         = irQ;
    maskNext       = maskQ;
    cntNext        = cntQ;

    case (state)
      IDLE: begin
        if (isMult) begin
          if (list == 8'd0) begin
            // Empty register list does nothing; emit a bubble.
            out_IR = NOP_WORD;
          end else begin
            reg_index      = cur;
            first_multiple = 1'b1;
            stall          = |rest;
            if (|rest) begin
              irNext    = in_IR;
              maskNext  = rest;
              cntNext   = 3'd1;
              stateNext = SEQ;
            end
          end
        end
      end
      SEQ: begin
        // IF/ID is frozen and don't-care here; replay the latched word.
        out_IR    = irQ;
        reg_index = cur;
        offset    = cntQ;
        stall     = |rest;
        maskNext  = rest;
        cntNext   = cntQ + 3'd1;
        if (rest == 8'd0) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase

    if (flush) begin
      out_IR         = NOP_WORD;
      reg_index      = 3'd0;
      offset         = 3'd0;
      first_multiple = 1'b0;
      stall          = 1'b0;
      stateNext      = IDLE;
      irNext         = 16'h0000;
      maskNext       = 8'd0;
      cntNext        = 3'd0;
    end else if (hold) begin
      // Freeze everything; outputs stay stable because state does not move.
      stall     = 1'b1;
      stateNext = state;
      irNext    = irQ;
      maskNext  = maskQ;
      cntNext   = cntQ;
    end

    // While reset is asserted the block looks like an idle pass-through,
    // even if IF/ID still holds the abandoned LM/SM.
    if (!reset) begin
      out_IR         = in_IR;
      reg_index      = 3'd0;
      offset         = 3'd0;
      first_multiple = 1'b0;
      stall          = 1'b0;
    end
  end

  // Sequencer state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      irQ   <= 16'h0000;
      maskQ <= 8'd0;
      cntQ  <= 3'd0;
    end else begin
      state <= stateNext;
      irQ   <= irNext;
      maskQ <= maskNext;
      cntQ  <= cntNext;
    end
  end

  assign busy = (state == SEQ);

endmodule

// File: tb/tb_multiple_sequencer.sv
// Directed table-driven bench for multiple_sequencer.
module tb_multiple_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] in_IR;
  logic        hold, flush;
  logic [15:0] out_IR;
  logic [2:0]  reg_index, offset;
  logic        first_multiple, stall, busy;

  int cmpCnt = 0;
  int errCnt = 0;

  multiple_sequencer dut (
    .clk(clk), .reset(reset), .in_IR(in_IR), .hold(hold), .flush(flush),
    .out_IR(out_IR), .reg_index(reg_index), .offset(offset),
    .first_multiple(first_multiple), .stall(stall), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] ir;
    logic        hold;
    logic        flush;
    logic [15:0] eIR;
    logic [2:0]  eReg;
    logic [2:0]  eOff;
    logic        eFirst;
    logic        eStall;
    logic        eBusy;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    cmpCnt++;
    if (act !== exp) begin
      errCnt++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chkAll(input string tag, input logic [15:0] eIR, input logic [2:0] eReg,
                        input logic [2:0] eOff, input logic eFirst, input logic eStall,
                        input logic eBusy);
    chk({tag, ".out_IR"}, out_IR, eIR);
    chk({tag, ".reg_index"}, 16'(reg_index), 16'(eReg));
    chk({tag, ".offset"}, 16'(offset), 16'(eOff));
    chk({tag, ".first_multiple"}, 16'(first_multiple), 16'(eFirst));
    chk({tag, ".stall"}, 16'(stall), 16'(eStall));
    chk({tag, ".busy"}, 16'(busy), 16'(eBusy));
  endtask

  task automatic add(input logic [15:0] ir, input logic h, input logic f, input logic [15:0] eIR,
                     input logic [2:0] eReg, input logic [2:0] eOff, input logic eFirst,
                     input logic eStall, input logic eBusy);
    vec_t v;
    v.ir = ir; v.hold = h; v.flush = f; v.eIR = eIR; v.eReg = eReg; v.eOff = eOff;
    v.eFirst = eFirst; v.eStall = eStall; v.eBusy = eBusy;
    vecs.push_back(v);
  endtask

  initial begin
    // ---- vector table (consecutive cycles, state carries between rows) ----
    // pass-through ADD
    add(16'h0298, 0, 0, 16'h0298, 0, 0, 0, 0, 0);
    // hold in IDLE forces stall only
    add(16'h0298, 1, 0, 16'h0298, 0, 0, 0, 1, 0);
    // three-register LM 6225: R0, R2, R5
    add(16'h6225, 0, 0, 16'h6225, 0, 0, 1, 1, 0);
    add(16'h6225, 0, 0, 16'h6225, 2, 1, 0, 1, 1);
    add(16'h6225, 0, 0, 16'h6225, 5, 2, 0, 0, 1);
    add(16'h0298, 0, 0, 16'h0298, 0, 0, 0, 0, 0);
    // empty list -> NOP bubble, no state change
    add(16'h6000, 0, 0, 16'hF000, 0, 0, 0, 0, 0);
    // single bit list: one cycle, busy never set
    add(16'h6080, 0, 0, 16'h6080, 7, 0, 1, 0, 0);
    add(16'h1234, 0, 0, 16'h1234, 0, 0, 0, 0, 0);
    // full-list SM with 2 hold cycles at offset 3 (IF/ID content don't-care)
    add(16'h70FF, 0, 0, 16'h70FF, 0, 0, 1, 1, 0);
    add(16'h0000, 0, 0, 16'h70FF, 1, 1, 0, 1, 1);
    add(16'h0000, 0, 0, 16'h70FF, 2, 2, 0, 1, 1);
    add(16'h0000, 1, 0, 16'h70FF, 3, 3, 0, 1, 1);
    add(16'h0000, 1, 0, 16'h70FF, 3, 3, 0, 1, 1);
    add(16'h0000, 0, 0, 16'h70FF, 3, 3, 0, 1, 1);
    add(16'h0000, 0, 0, 16'h70FF, 4, 4, 0, 1, 1);
    add(16'h0000, 0, 0, 16'h70FF, 5, 5, 0, 1, 1);
    add(16'h0000, 0, 0, 16'h70FF, 6, 6, 0, 1, 1);
    add(16'h0000, 0, 0, 16'h70FF, 7, 7, 0, 0, 1);
    add(16'h0298, 0, 0, 16'h0298, 0, 0, 0, 0, 0);
    // flush in the second cycle of a 4-register LM
    add(16'h600F, 0, 0, 16'h600F, 0, 0, 1, 1, 0);
    add(16'h600F, 0, 1, 16'hF000, 0, 0, 0, 0, 1);
    add(16'h0298, 0, 0, 16'h0298, 0, 0, 0, 0, 0);
    // flush and hold together: flush wins
    add(16'h6003, 0, 0, 16'h6003, 0, 0, 1, 1, 0);
    add(16'h6003, 1, 1, 16'hF000, 0, 0, 0, 0, 1);
    add(16'hABCD, 0, 0, 16'hABCD, 0, 0, 0, 0, 0);
    // flush on an LM presented in IDLE: sequence never starts
    add(16'h6225, 0, 1, 16'hF000, 0, 0, 0, 0, 0);
    add(16'h0298, 0, 0, 16'h0298, 0, 0, 0, 0, 0);

    // ---- reset state ----
    reset = 1'b0; in_IR = 16'h0298; hold = 1'b0; flush = 1'b0;
    #1;
    chkAll("reset", 16'h0298, 0, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b1;

    // ---- apply table ----
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      in_IR = vecs[i].ir; hold = vecs[i].hold; flush = vecs[i].flush;
      #1;
      chkAll($sformatf("vec%0d", i), vecs[i].eIR, vecs[i].eReg, vecs[i].eOff,
             vecs[i].eFirst, vecs[i].eStall, vecs[i].eBusy);
    end

    // ---- reset mid-sequence, no clock edge ----
    @(negedge clk);
    in_IR = 16'h6225; hold = 1'b0; flush = 1'b0;
    #1;
    chkAll("rstSeq.c0", 16'h6225, 0, 0, 1, 1, 0);
    @(negedge clk);
    #1;
    chkAll("rstSeq.c1", 16'h6225, 2, 1, 0, 1, 1);
    reset = 1'b0;
    #1;
    chkAll("rstSeq.async", 16'h6225, 0, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b1;
    in_IR = 16'h0298;
    #1;
    chkAll("rstSeq.after", 16'h0298, 0, 0, 0, 0, 0);
    // a fresh LM after reset starts from its first register again
    @(negedge clk);
    in_IR = 16'h6006;
    #1;
    chkAll("rstSeq.new0", 16'h6006, 1, 0, 1, 1, 0);
    @(negedge clk);
    #1;
    chkAll("rstSeq.new1", 16'h6006, 2, 1, 0, 0, 1);
    @(negedge clk);
    in_IR = 16'h0298;
    #1;
    chkAll("rstSeq.idle", 16'h0298, 0, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCnt, errCnt);
    $finish;
  end

endmodule
